// File: rtl/itof_rm_pipe.sv
// rtl/itof_rm_pipe.sv - signed/unsigned integer to binary32 converter, 3-stage pipeline
// Per-operation rounding mode, inexact flag and sideband tag; full valid/ready backpressure.
module itof_rm_pipe #(
  parameter int INT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INT_W-1:0] in_i,
  input  logic             in_signed,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [31:0]      out_f,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int M  = INT_W + 1;
  localparam int IW = $clog2(M);
  localparam int N  = M + 26;

  logic adv;
  assign adv         = !out_valid || out_ready;
  assign input_ready = adv;

  // One extra magnitude bit so that the most negative signed operand negates cleanly.
  logic         neg;
  logic [M-1:0] ext;
  logic [M-1:0] mag;
  assign neg = in_signed & in_i[INT_W-1];
  assign ext = {neg, in_i};
  assign mag = neg ? (~ext + M'(1)) : ext;

  logic             s1_valid;
  logic             s1_sign;
  logic [M-1:0]     s1_mag;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  logic [IW-1:0] lead;
  logic [IW-1:0] shamt;
  always_comb begin
    lead = '0;
    for (int i = 0; i < M; i++) begin
      if (s1_mag[i]) lead = IW'(i);
    end
  end
  assign shamt = IW'(M - 1) - lead;

  logic             s2_valid;
  logic             s2_sign;
  logic [M-1:0]     s2_norm;
  logic [7:0]       s2_exp;
  logic [2:0]       s2_rm;
  logic [TAG_W-1:0] s2_tag;

  // Zero padding below the normalised value keeps guard/sticky defined for narrow INT_W.
  logic [N-1:0] wide;
  logic         hidden;
  logic         lsb;
  logic         guard;
  logic         sticky;
  logic         inexact;
  logic         inc;
  logic [23:0]  fsum;
  logic [7:0]   exp_r;
  assign wide    = {s2_norm, 26'd0};
  assign hidden  = wide[N-1];
  assign lsb     = wide[N-24];
  assign guard   = wide[N-25];
  assign sticky  = |wide[N-26:0];
  assign inexact = guard | sticky;

  always_comb begin
    inc = 1'b0;
    case (s2_rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = inexact & s2_sign;
      3'd3:    inc = inexact & !s2_sign;
      3'd4:    inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
  end

  // A carry out of the fraction means the significand rolled over to 1.0 of the next binade.
  assign fsum  = {1'b0, wide[N-2 -: 23]} + 24'(inc);
  assign exp_r = fsum[23] ? s2_exp + 8'd1 : s2_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_mag      <= '0;
      s1_rm       <= 3'd0;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_norm     <= '0;
      s2_exp      <= 8'd0;
      s2_rm       <= 3'd0;
      s2_tag      <= '0;
      out_valid   <= 1'b0;
      out_f       <= 32'd0;
      out_inexact <= 1'b0;
      out_tag     <= '0;
    end else if (adv) begin
      s1_valid    <= input_valid;
      s1_sign     <= neg;
      s1_mag      <= mag;
      s1_rm       <= in_rm;
      s1_tag      <= in_tag;
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_norm     <= s1_mag << shamt;
      s2_exp      <= 8'd127 + 8'(lead);
      s2_rm       <= s1_rm;
      s2_tag      <= s1_tag;
      out_valid   <= s2_valid;
      out_f       <= hidden ? {s2_sign, exp_r, fsum[22:0]} : 32'd0;
      out_inexact <= hidden & inexact;
      out_tag     <= s2_tag;
    end
  end
endmodule

// File: doc/itof_rm_pipe.md
Name: itof_rm_pipe

Overview:
Parametrised successor to the 32-bit itof converter. Converts a signed or unsigned INT_W-bit integer to IEEE-754 binary32, with a per-transaction rounding mode and an inexact flag. It is a fixed 3-stage pipeline with full valid/ready backpressure and a sideband tag. It sits in the FPU between the issue path and the FP writeback arbiter.

Parameters:
INT_W, 32, integer input width; legal range 8..64.
TAG_W, 4, width of the opaque sideband tag carried alongside each operation; legal range 1..16.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_i  in  INT_W  integer operand
in_signed  in  1  1 = two's-complement operand, 0 = unsigned operand
in_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5..7 treated as RNE
in_tag  in  TAG_W  sideband tag, returned unchanged with the result
input_valid  in  1  operand valid
input_ready  out  1  converter can accept an operand this cycle
out_f  out  32  binary32 result
out_inexact  out  1  result was rounded (not exactly representable)
out_tag  out  TAG_W  tag of the operation on out_f
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result

Behaviour:
- Reset: asynchronous assert, synchronous release. During reset all stage valid bits clear. out_valid=0, out_f=0, out_inexact=0, out_tag=0. input_ready=1 one cycle after reset release.
- Pipeline: S1 extracts the sign, computes the magnitude and captures rm and tag. S2 runs a leading-zero count and normalising left shift. S3 rounds, handles the exponent bump on mantissa overflow, and packs the result. S3 drives the outputs directly from registers; there is no combinational path from in_* to out_*.
- Advance: adv = !out_valid || out_ready. All stages move together when adv=1 and hold when adv=0.
- input_ready = adv. This is a combinational path from out_ready.
- Accept: an operand is accepted on an edge where input_valid && input_ready.
- Latency: with no stall, an operand accepted on edge k has out_valid=1 after edge k+2, i.e. 3 register stages.
- Throughput: one result per cycle. Bubbles propagate as invalid stages. Results leave in acceptance order.
- Stall: while out_valid && !out_ready, out_f, out_inexact and out_tag hold stable. No operand is accepted and nothing is lost or duplicated.
- Magnitude: internal magnitude width is INT_W+1 bits, so signed INT_MIN (e.g. 0x80000000 at INT_W=32) is handled without overflow.
- Unsigned operands always produce sign=0.
- Zero input: out_f=0x00000000 (+0) in every mode, inexact=0.
- Exponent: biased exponent = 127 + (index of the leading one). It never overflows for INT_W<=64, and the result is never denormal.
- Rounding inputs: guard is the bit below the 24-bit significand; sticky is the OR of all lower bits. inexact = guard|sticky.
- RNE: increment if guard && (sticky || lsb).
- RTZ: never increment.
- RDN: increment if inexact && sign.
- RUP: increment if inexact && !sign.
- RMM: increment if guard.
- Mantissa overflow on increment: the mantissa becomes 0 and the exponent increments.
- INT_W<=24: every input is exact; inexact is always 0.
- Mid-operation reset: all in-flight operations are discarded and no stale out_valid appears after release.

Test Plan:
- INT_W=32, RNE, signed: inputs 0, 1, -1, INT_MIN -> 0x00000000, 0x3F800000, 0xBF800000, 0xCF000000; inexact=0 for all.
- 16777217 signed: RNE -> 0x4B800000, RUP -> 0x4B800001, RTZ -> 0x4B800000; inexact=1 in all three.
- -16777217 signed: RDN -> 0xCB800001, RUP -> 0xCB800000.
- 16777219 signed, RMM -> 0x4B800002.
- 0xFFFFFFFF unsigned: RNE -> 0x4F800000, RTZ -> 0x4F7FFFFF.
- 0xFFFFFFFF signed: -> 0xBF800000.
- Backpressure: stream 20 back-to-back random operands with tags 0..F wrapping, and hold out_ready=0 for 5 cycles mid-stream.
  - input_ready must drop in the same cycle.
  - Outputs must stay stable while stalled.
  - All 20 results must appear in order with correct tags and values against the shortreal model, or a per-mode software model.
- Reset mid-flight: accept 2 operands, then assert rst_n=0 for 1 cycle.
  - out_valid=0 immediately.
  - No result appears for the dropped operands.
  - The next operand returns at latency 3.
- INT_W=64 build:
  - 2^63 unsigned -> 0x5F000000.
  - 0x7FFFFFFFFFFFFFFF signed RNE -> 0x5F000000 with inexact=1; RTZ -> 0x5EFFFFFF.
  - INT_W=16 build: -32768 -> 0xC7000000, inexact=0.
